// File: rtl/i2c_globals_pkg.sv
// Shared I2C target definitions: FSM state encoding, ACK levels and helpers.
package i2c_globals_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_target_state_e;

  localparam logic       I2C_ACK              = 1'b0;
  localparam logic       I2C_NACK             = 1'b1;
  localparam logic [6:0] GENERAL_CALL_ADDRESS = 7'h00;

  // Register pointer increment with wrap at the top of the register file.
  function automatic logic [7:0] ptr_next(input logic [7:0] ptr, input int unsigned n_reg);
    return ((32'(ptr) + 32'd1) >= n_reg) ? 8'h00 : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Pin/debug bundle of the I2C register-file target; slave = target side.
interface i2c_target_regfile_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       busy;
  logic       wr_valid;
  logic [7:0] wr_index;
  logic [7:0] wr_data;
  logic [7:0] dbg_index;
  logic [7:0] dbg_data;

  modport slave (
    input  scl_i, sda_i, dbg_index,
    output sda_oe, busy, wr_valid, wr_index, wr_data, dbg_data
  );

  modport master (
    output scl_i, sda_i, dbg_index,
    input  sda_oe, busy, wr_valid, wr_index, wr_data, dbg_data
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Two-flop SCL/SDA synchroniser with registered edge, START and STOP detection.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_q;
  logic       sda_q;

  // sda_s is registered alongside the edge flags so a bit is sampled in the same cycle as scl_rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      sda_s     <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[0], scl_i};
      sda_sync  <= {sda_sync[0], sda_i};
      scl_q     <= scl_sync[1];
      sda_q     <= sda_sync[1];
      scl_rise  <= scl_sync[1] & ~scl_q;
      scl_fall  <= ~scl_sync[1] & scl_q;
      start_det <= scl_sync[1] & scl_q & sda_q & ~sda_sync[1];
      stop_det  <= scl_sync[1] & scl_q & ~sda_q & sda_sync[1];
      sda_s     <= sda_sync[1];
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with register file: address match, register pointer, auto-increment writes/reads.
// Optional I2C_GENERAL_CALL_EN: ACK 7'h00+W and write the following byte to register 0.
module i2c_target_regfile
  import i2c_globals_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDRESS = 7'h68,
  parameter int unsigned NO_OF_REG     = 4,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input logic                 pclk,
  input logic                 areset,
  i2c_target_regfile_if.slave bus
);

  localparam int unsigned IDX_W     = (NO_OF_REG > 1) ? $clog2(NO_OF_REG) : 1;
  localparam logic [3:0]  BYTE_BITS = 4'(DATA_WIDTH);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_sync_edge u_sync (
    .clk       (pclk),
    .rst       (areset),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_target_state_e     state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [3:0]            bit_cnt;
  logic [7:0]            reg_ptr;
  logic                  mst_ack;
  logic                  gcall;
  logic                  sda_oe_q;
  logic                  busy_q;
  logic                  wr_valid_q;
  logic [7:0]            wr_index_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] dbg_data_q;
  logic [DATA_WIDTH-1:0] regfile [NO_OF_REG];

  logic [DATA_WIDTH-1:0] rx_byte;
  logic [DATA_WIDTH-1:0] cur_reg;
  logic [7:0]            ptr_inc;
  logic [IDX_W-1:0]      wr_slot;

  assign rx_byte = {shreg[DATA_WIDTH-2:0], sda_s};
  assign cur_reg = regfile[reg_ptr[IDX_W-1:0]];
  assign ptr_inc = ptr_next(reg_ptr, NO_OF_REG);
  assign wr_slot = gcall ? '0 : reg_ptr[IDX_W-1:0];

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_index = wr_index_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.dbg_data = dbg_data_q;

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      reg_ptr    <= '0;
      mst_ack    <= 1'b0;
      gcall      <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
      regfile    <= '{default: '0};
    end else begin
      wr_valid_q <= 1'b0;
      if (stop_det) begin
        state    <= IDLE;
        reg_ptr  <= '0;
        bit_cnt  <= '0;
        gcall    <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        // reg_ptr survives a repeated START so a write-address phase can precede a read
        state    <= ADDR;
        bit_cnt  <= '0;
        gcall    <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && bit_cnt < BYTE_BITS) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == BYTE_BITS) begin
              bit_cnt <= '0;
              if (shreg[7:1] == SLAVE_ADDRESS) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                state    <= ADDR_ACK;
              end
`ifdef I2C_GENERAL_CALL_EN
              else if (shreg[7:1] == GENERAL_CALL_ADDRESS && !shreg[0]) begin
                sda_oe_q <= 1'b1;
                busy_q   <= 1'b1;
                gcall    <= 1'b1;
                state    <= ADDR_ACK;
              end
`endif
              else begin
                state <= WAIT_STOP;
              end
            end
          end

          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (gcall) begin
                sda_oe_q <= 1'b0;
                state    <= WR_DATA;
              end else if (shreg[0]) begin
                shreg    <= cur_reg;
                sda_oe_q <= ~cur_reg[DATA_WIDTH-1];
                state    <= RD_DATA;
              end else begin
                sda_oe_q <= 1'b0;
                state    <= REG_ADDR;
              end
            end
          end

          REG_ADDR: begin
            if (scl_rise && bit_cnt < BYTE_BITS) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == BYTE_BITS) begin
              bit_cnt <= '0;
              if ({1'b0, shreg} < 9'(NO_OF_REG)) begin
                sda_oe_q <= 1'b1;
                reg_ptr  <= shreg;
                state    <= REG_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          REG_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= WR_DATA;
            end
          end

          WR_DATA: begin
            if (scl_rise && bit_cnt < BYTE_BITS) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              // Commit on the rising edge that samples the last bit; ACK follows on the fall
              if (bit_cnt == BYTE_BITS - 4'd1) begin
                regfile[wr_slot] <= rx_byte;
                wr_valid_q       <= 1'b1;
                wr_index_q       <= 8'(wr_slot);
                wr_data_q        <= rx_byte;
                if (!gcall) reg_ptr <= ptr_inc;
              end
            end else if (scl_fall && bit_cnt == BYTE_BITS) begin
              sda_oe_q <= 1'b1;
              bit_cnt  <= '0;
              state    <= WR_ACK;
            end
          end

          WR_ACK: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= gcall ? WAIT_STOP : WR_DATA;
            end
          end

          RD_DATA: begin
            if (scl_rise && bit_cnt < BYTE_BITS) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == BYTE_BITS) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              mst_ack  <= 1'b0;
              state    <= RD_ACK;
            end else if (scl_fall && bit_cnt != 4'd0) begin
              shreg    <= {shreg[DATA_WIDTH-2:0], 1'b0};
              sda_oe_q <= ~shreg[DATA_WIDTH-2];
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              mst_ack <= (sda_s == I2C_ACK);
              if (sda_s == I2C_ACK) reg_ptr <= ptr_inc;
            end else if (scl_fall) begin
              if (mst_ack) begin
                shreg    <= cur_reg;
                sda_oe_q <= ~cur_reg[DATA_WIDTH-1];
                state    <= RD_DATA;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          IDLE, WAIT_STOP: begin
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      dbg_data_q <= '0;
    end else if (32'(bus.dbg_index) < NO_OF_REG) begin
      dbg_data_q <= regfile[bus.dbg_index[IDX_W-1:0]];
    end else begin
      dbg_data_q <= '0;
    end
  end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

Synthesizable, parametrised I2C target (slave) engine with an internal register file. It is the RTL counterpart of the AVIP slave agent and serves as the DUT behind the I2C interface. It decodes START/STOP/repeated START and matches its slave address. It accepts a register-address byte, then performs multi-byte writes or reads with pointer auto-increment.

## Interface
- SLAVE_ADDRESS, 7'h68: 7-bit address this target responds to.
- NO_OF_REG, 4: number of registers; legal range 1–256.
- DATA_WIDTH, 8: register width; fixed at 8 by the I2C byte format; other values are illegal.
- pclk  input  1  system clock; must be at least 8× the SCL frequency.
- areset  input  1  asynchronous, active-high reset.
- scl_i  input  1  raw SCL pin value.
- sda_i  input  1  raw SDA pin value.
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- busy  output  1  high while this target is addressed (from address ACK until STOP or repeated START).
- wr_valid  output  1  one-pclk pulse when a bus-written byte commits to the register file.
- wr_index  output  8  register index of the committed byte.
- wr_data  output  8  committed byte.
- dbg_index  input  8  debug read-port index.
- dbg_data  output  8  regfile[dbg_index], registered; 1-cycle latency; 0 if the index is out of range.

## Operation
- SCL and SDA pass through 2-flop synchronisers, then a registered edge detector.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
- Bits are sampled on SCL rising. sda_oe changes only on SCL falling.
- The shifter is MSB first.
- FSM states:
  - IDLE
  - ADDR: 7 address bits + R/W.
  - ADDR_ACK
  - REG_ADDR
  - REG_ACK
  - WR_DATA
  - WR_ACK
  - RD_DATA
  - RD_ACK: samples the master's ACK.
  - WAIT_STOP
- IDLE→ADDR on START. START in any state→ADDR (repeated START). STOP in any state→IDLE.
- ADDR: on a match, ACK, then REG_ADDR (W) or RD_DATA (R). On a mismatch, sda_oe stays 0 and the FSM goes to WAIT_STOP.
- REG_ADDR: byte < NO_OF_REG → ACK, reg_ptr = byte, then WR_DATA. Byte ≥ NO_OF_REG → NACK, then WAIT_STOP.
- WR_DATA: after the 8th bit, commit to regfile[reg_ptr], pulse wr_valid, ACK.
  - reg_ptr increments and wraps NO_OF_REG-1 → 0.
- RD_DATA: the shifter loads regfile[reg_ptr] at the ACK-cycle SCL falling edge, and each bit is driven onto SDA: sda_oe = ~bit.
  - RD_ACK: master ACK (SDA low) → reg_ptr++ (wraps), load the next byte.
  - Master NACK → WAIT_STOP.
- reg_ptr persists across repeated START (write-address-then-read sequence) and clears on STOP and areset.
- A bus write and a dbg read of the same index in the same cycle: dbg_data returns the old value.

## Timing
- Pin-to-internal latency: 3 pclk (2 sync + 1 edge).
- ACK: sda_oe rises 1 pclk after the synced SCL falling edge that ends bit 8. It falls 1 pclk after the next synced SCL falling edge.
- wr_valid is asserted 1 pclk after the SCL rising edge that samples bit 8 of a data byte; wr_index and wr_data are valid in the same cycle.
- Reset values: sda_oe 0, busy 0, wr_valid 0, wr_index 0, wr_data 0, dbg_data 0.
- Internal reset state: FSM IDLE, regfile all 0, reg_ptr 0, synchronisers 1.
- areset mid-transfer: outputs return to their reset values immediately; SDA is released asynchronously.

## Configuration
- I2C_GENERAL_CALL_EN
  - Defined: address 7'h00 with W is ACKed; the next byte is written to register 0 (no register-address phase) with wr_valid pulsed, then WAIT_STOP. A general call with R is NACKed.
  - Undefined: 7'h00 is treated as any mismatched address.

## Structure
- Shared package (i2c_globals_pkg): i2c_target_state_e (the FSM states above), I2C_ACK = 1'b0, I2C_NACK = 1'b1, GENERAL_CALL_ADDRESS = 7'h00.
- Sub-module i2c_sync_edge: 2-flop synchroniser plus edge/START/STOP detection; outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

## Test plan
- Write 68+W, reg 8'h02, data 8'hA5, STOP → three ACKs; wr_valid with index 2 and data A5; dbg_index=2 gives dbg_data=A5.
- Write reg 8'h03, data 11 then 22 (NO_OF_REG=4) → regfile[3]=11, regfile[0]=22 (wrap).
- Write reg 01, repeated START, 68+R, master reads 2 bytes with ACK then NACK → bytes regfile[1], regfile[2]; SDA released after the NACK.
- Address 6C+W → no ACK, busy stays 0, regfile unchanged. Register address 8'h09 → NACK after that byte.
- General call 00+W, data 8'h5A → with the macro defined: ACK, regfile[0]=5A. Without it: NACK, no write.
- areset pulsed during the 4th data bit → sda_oe=0 and busy=0 within the same cycle; regfile cleared; the next START+address is handled normally.
